// File: rtl/shifter_arbiter.sv
// Round-robin arbiter that time-shares one combinational 32-bit shifter among
// four valid/ready requesters, with registered operands and a registered result.

module shifter_32 (
    input  logic [31:0] a,
    input  logic [4:0]  b,
    input  logic [1:0]  c,
    output logic [31:0] z
);
    always_comb begin
        case (c)
            2'b10:   z = a >> b;
            2'b11:   z = 32'($signed(a) >>> b);
            default: z = a << b;
        endcase
    end
endmodule

module shifter_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*5-1:0]        req_b,
    input  logic [NUM_REQ*2-1:0]        req_c,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [1:0]                  rsp_id,
    output logic [DATA_W-1:0]           rsp_z,
    output logic [CNT_W-1:0]            op_count
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [4:0]        op_b_q, op_b_d;
    logic [1:0]        op_c_q, op_c_d;
    logic [1:0]        op_id_q, op_id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [1:0]        rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_z_q, rsp_z_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;

    logic              grant_found;
    logic [1:0]        grant_id;
    logic [1:0]        cand;
    logic [DATA_W-1:0] shift_z;

    shifter_32 u_shifter (
        .a (op_a_q),
        .b (op_b_q),
        .c (op_c_q),
        .z (shift_z)
    );

    // Scan from the far end back towards ptr so the nearest valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = ptr_q;
        cand        = ptr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_found && !rst) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_c_d      = op_c_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_z_d     = rsp_z_q;
        op_count_d  = op_count_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    op_a_d  = req_a[DATA_W*grant_id +: DATA_W];
                    op_b_d  = req_b[5*grant_id +: 5];
                    op_c_d  = req_c[2*grant_id +: 2];
                    op_id_d = grant_id;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_z_d     = shift_z;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    ptr_d       = rsp_id_q + 2'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_c_q      <= '0;
            op_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_z_q     <= '0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_c_q      <= op_c_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_z_q     <= rsp_z_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_z     = rsp_z_q;
    assign op_count  = op_count_q;
endmodule

// File: doc/shifter_arbiter.md
Name: shifter_arbiter

Overview:
- Shares one 32-bit combinational shifter (shifter_32, instantiated internally) among 4 requesters.
- Each requester uses a valid/ready handshake. Grants are round-robin.
- Operands are registered before the shifter, and the result is registered after it.
- Sits between the requesting datapath units and the shared shift resource. Returns one tagged response per accepted request.

Parameters:
- NUM_REQ, 4, number of requesters. Fixed at 4; the id is 2 bits wide.
- DATA_W, 32, operand/result width. Fixed at 32 to match the shifter.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  4  per-requester request valid.
- req_ready  out  4  per-requester accept; at most one bit high.
- req_a  in  128  operands; requester i uses bits [32i+31:32i].
- req_b  in  20  shift amounts; requester i uses bits [5i+4:5i], unsigned 0..31.
- req_c  in  8  shift types; requester i uses bits [2i+1:2i]. 00/01 = logical left, 10 = logical right, 11 = arithmetic right.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  2  index of the requester that owns the result.
- rsp_z  out  32  shift result.
- op_count  out  CNT_W  number of completed responses.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, rr pointer ptr=0.
  - rsp_valid=0, rsp_id=0, rsp_z=0, op_count=0.
  - Operand registers cleared to 0.
  - req_ready=0 while rst=1.
- Reset mid-operation aborts the operation: the captured request is discarded and no response is issued.
- States: IDLE, EXEC, RESP.
- IDLE:
  - grant = first i with req_valid[i]=1, searching ptr, ptr+1, ... mod 4.
  - req_ready = one-hot(grant), combinational from req_valid and ptr. All zero if no req_valid bit is set.
  - On handshake (req_valid[g] & req_ready[g]): capture a/b/c of requester g into operand regs, capture id=g, go to EXEC.
  - No request: stay in IDLE.
- EXEC:
  - Drive the shifter from the operand regs.
  - Load rsp_z with the shifter output and rsp_id with the captured id. Set rsp_valid=1 and go to RESP.
  - req_ready=0.
- RESP:
  - rsp_valid=1. rsp_z and rsp_id held stable until the handshake.
  - req_ready=0.
  - On rsp_valid & rsp_ready at an edge:
    - rsp_valid<=0
    - op_count<=op_count+1, wrapping at 2^CNT_W to 0
    - ptr<=(rsp_id+1) mod 4
    - go to IDLE
- Latency: request handshake at edge N → rsp_valid=1 after edge N+1. Minimum 3 cycles per operation; one operation outstanding.
- A requester that drops req_valid before its handshake is not served, and ptr is not advanced.
- Request operands are sampled only at the handshake edge. Later changes to req_a/req_b/req_c do not affect the in-flight result.
- req_valid asserted during EXEC/RESP waits; it is arbitrated in IDLE using the updated ptr.
- Shift semantics:
  - b=0 passes the operand through unchanged for all c.
  - Left shifts fill with 0.
  - Logical right fills with 0.
  - Arithmetic right fills with operand bit 31.
- rsp_ready asserted while rsp_valid=0 has no effect.

Test Plan:
- Reset, then requester 0: a=0x80000000, b=4, c=11 → req_ready=0001 in the same cycle; rsp_valid two edges later; rsp_z=0xF8000000, rsp_id=0, op_count=1 after the handshake.
- Requester 2: a=0x80000000, b=4, c=10 → rsp_z=0x08000000, rsp_id=2. Requester 1: a=0x00000001, b=31, c=01 → rsp_z=0x80000000. Requester 3: a=0x12345678, b=0, c=11 → rsp_z=0x12345678.
- All four req_valid held high from reset, rsp_ready=1 → grant order 0,1,2,3,0. Each response 3 cycles apart. op_count=5 after 5 responses.
- In RESP hold rsp_ready=0 for 5 cycles with req_valid=1111 → rsp_valid stays 1, rsp_z/rsp_id stable, req_ready=0000 throughout. Release → next grant goes to rsp_id+1.
- Assert rst=1 for one cycle during EXEC of a request from requester 1 → next cycle rsp_valid=0, op_count=0, state IDLE, ptr=0. No response is ever issued for the aborted request.
- Force op_count=0xFFFF (via 65535 operations or a backdoor) and complete one more operation → op_count wraps to 0x0000.
